// File: rtl/approx_err_pkg.sv
// Shared types and default widths for the approximate-multiplier error accumulator.
package approx_err_pkg;

  localparam int OP_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  localparam int PROD_W    = 2 * OP_W_DEF;
  localparam int DIFF_W    = PROD_W + 1;
  localparam int SQ_W      = 2 * PROD_W;
  localparam int SQ_ACC_W  = SQ_W + CNT_W_DEF;
  localparam int ABS_ACC_W = PROD_W + CNT_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

endpackage

// File: rtl/approx_err_pipe.sv
// Three-stage error datapath: exact product, |p - a*b| and mismatch, then square.
module approx_err_pipe
  import approx_err_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  input  logic [2*OP_W-1:0] p,
  output logic              err_valid,
  output logic [4*OP_W-1:0] err_sq,
  output logic [2*OP_W-1:0] err_abs,
  output logic              err_mism,
  output logic              pipe_busy
);

  localparam int PW = 2 * OP_W;
  localparam int DW = PW + 1;
  localparam int SW = 2 * PW;

  logic          v1;
  logic [PW-1:0] p1;
  logic [PW-1:0] prod1;

  logic          v2;
  logic [DW-1:0] d2;
  logic [PW-1:0] abs2;
  logic          mism2;

  logic [DW-1:0] diff;
  logic [DW-1:0] diff_mag;

  // Signed difference and its magnitude; |d| never exceeds 2^PW-1 so the top bit is dropped.
  always_comb begin
    diff = {1'b0, p1} - {1'b0, prod1};
    if (diff[DW-1]) begin
      diff_mag = ~diff + {{(DW-1){1'b0}}, 1'b1};
    end else begin
      diff_mag = diff;
    end
  end

  // S1: capture the approximate product and recompute the exact one.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      p1    <= {PW{1'b0}};
      prod1 <= {PW{1'b0}};
    end else begin
      v1 <= sample_valid;
      if (sample_valid) begin
        p1    <= p;
        prod1 <= {{OP_W{1'b0}}, a} * {{OP_W{1'b0}}, b};
      end
    end
  end

  // S2: signed difference, magnitude and mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      d2    <= {DW{1'b0}};
      abs2  <= {PW{1'b0}};
      mism2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        d2    <= diff;
        abs2  <= diff_mag[PW-1:0];
        mism2 <= (p1 != prod1);
      end
    end
  end

  // S3: square of the difference (computed from |d|, identical to d*d) plus |d| for accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_sq    <= {SW{1'b0}};
      err_abs   <= {PW{1'b0}};
      err_mism  <= 1'b0;
    end else begin
      err_valid <= v2;
      if (v2) begin
        err_sq   <= {{PW{1'b0}}, abs2} * {{PW{1'b0}}, abs2};
        err_abs  <= abs2;
        err_mism <= mism2 & (d2 != {DW{1'b0}});
      end
    end
  end

  assign pipe_busy = v1 | v2 | err_valid;

endmodule

// File: rtl/approx_mult_err_acc.sv
// Windowed error-statistics accumulator for approximate 8x8 multipliers.
// Optional feature macro: APPROX_ERR_MAX_EN enables the running maximum of |d|.
module approx_mult_err_acc
  import approx_err_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        win_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_a,
  input  logic [OP_W-1:0]         in_b,
  input  logic [2*OP_W-1:0]       in_p,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*OP_W+CNT_W-1:0] sum_sq_err,
  output logic [2*OP_W+CNT_W-1:0] sum_abs_err,
  output logic [CNT_W:0]          err_cnt,
  output logic [2*OP_W-1:0]       max_abs_err
);

  localparam int PW = 2 * OP_W;
  localparam int SW = 4 * OP_W;

  state_t         state;
  state_t         nxt;
  logic [CNT_W:0] remaining;

  logic           accept;
  logic           last_accept;
  logic           start_ok;

  logic           err_valid;
  logic [SW-1:0]  err_sq;
  logic [PW-1:0]  err_abs;
  logic           err_mism;
  logic           pipe_busy;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (remaining == {{CNT_W{1'b0}}, 1'b1});
  assign start_ok    = (state == ST_IDLE) & start;

  approx_err_pipe #(.OP_W(OP_W)) u_pipe (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (accept),
    .a            (in_a),
    .b            (in_b),
    .p            (in_p),
    .err_valid    (err_valid),
    .err_sq       (err_sq),
    .err_abs      (err_abs),
    .err_mism     (err_mism),
    .pipe_busy    (pipe_busy)
  );

  // Next-state logic for the window controller.
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) nxt = ST_RUN;
        else       nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (last_accept) nxt = ST_DRAIN;
        else             nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (!pipe_busy) nxt = ST_RESULT;
        else            nxt = ST_DRAIN;
      end
      ST_RESULT: begin
        if (res_ready) nxt = ST_IDLE;
        else           nxt = ST_RESULT;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State register and registered handshake/status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= nxt;
      in_ready  <= (nxt == ST_RUN);
      busy      <= (nxt != ST_IDLE);
      res_valid <= (nxt == ST_RESULT);
    end
  end

  // Remaining-sample counter; a zero window length means the full 2^CNT_W samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= {(CNT_W+1){1'b0}};
    end else if (start_ok) begin
      if (win_len == {CNT_W{1'b0}}) remaining <= {1'b1, {CNT_W{1'b0}}};
      else                          remaining <= {1'b0, win_len};
    end else if (accept) begin
      remaining <= remaining - {{CNT_W{1'b0}}, 1'b1};
    end else begin
      remaining <= remaining;
    end
  end

  // Error accumulators: cleared on an accepted start, summed from S3, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_sq_err  <= {(SW+CNT_W){1'b0}};
      sum_abs_err <= {(PW+CNT_W){1'b0}};
      err_cnt     <= {(CNT_W+1){1'b0}};
    end else if (start_ok) begin
      sum_sq_err  <= {(SW+CNT_W){1'b0}};
      sum_abs_err <= {(PW+CNT_W){1'b0}};
      err_cnt     <= {(CNT_W+1){1'b0}};
    end else if (err_valid) begin
      sum_sq_err  <= sum_sq_err + {{CNT_W{1'b0}}, err_sq};
      sum_abs_err <= sum_abs_err + {{CNT_W{1'b0}}, err_abs};
      err_cnt     <= err_cnt + {{CNT_W{1'b0}}, err_mism};
    end else begin
      sum_sq_err  <= sum_sq_err;
      sum_abs_err <= sum_abs_err;
      err_cnt     <= err_cnt;
    end
  end

`ifdef APPROX_ERR_MAX_EN
  // Running maximum of |d| over the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_abs_err <= {PW{1'b0}};
    end else if (start_ok) begin
      max_abs_err <= {PW{1'b0}};
    end else if (err_valid && (err_abs > max_abs_err)) begin
      max_abs_err <= err_abs;
    end else begin
      max_abs_err <= max_abs_err;
    end
  end
`else
  assign max_abs_err = {PW{1'b0}};
`endif

endmodule

// File: tb/tb_approx_mult_err_acc.sv
// Directed, scoreboard-based bench for approx_mult_err_acc.
module tb_approx_mult_err_acc;

  localparam int OP_W  = 8;
  localparam int CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [CNT_W-1:0]        win_len = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [OP_W-1:0]         in_a = '0;
  logic [OP_W-1:0]         in_b = '0;
  logic [2*OP_W-1:0]       in_p = '0;
  logic                    busy;
  logic                    res_valid;
  logic                    res_ready = 1'b0;
  logic [4*OP_W+CNT_W-1:0] sum_sq_err;
  logic [2*OP_W+CNT_W-1:0] sum_abs_err;
  logic [CNT_W:0]          err_cnt;
  logic [2*OP_W-1:0]       max_abs_err;

  approx_mult_err_acc #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .win_len     (win_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_p        (in_p),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum_sq_err  (sum_sq_err),
    .sum_abs_err (sum_abs_err),
    .err_cnt     (err_cnt),
    .max_abs_err (max_abs_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint sq;
    longint ab;
    longint cnt;
    longint mx;
  } res_t;

  res_t   exp_q[$];
  res_t   cur;
  longint m_sq, m_ab, m_cnt, m_mx;
  int     vectors = 0;
  int     miscompares = 0;
  int unsigned last_acc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic open_win(input int w);
    win_len = 16'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ready_after_start", {63'd0, in_ready}, 64'd1);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    m_sq = 0; m_ab = 0; m_cnt = 0; m_mx = 0;
  endtask

  task automatic send(input int a, input int b, input int p);
    int n;
    longint d, ad;
    in_a = 8'(a); in_b = 8'(b); in_p = 16'(p);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      tick();
      in_valid = 1'b0;
      last_acc = cyc;
      d  = longint'(p) - longint'(a) * longint'(b);
      ad = (d < 0) ? -d : d;
      m_sq += ad * ad;
      m_ab += ad;
      if (d != 0) m_cnt++;
      if (ad > m_mx) m_mx = ad;
    end
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    in_a = 8'($urandom); in_b = 8'($urandom); in_p = 16'($urandom);
    tick();
  endtask

  task automatic close_win();
    res_t r;
    r.sq = m_sq; r.ab = m_ab; r.cnt = m_cnt;
`ifdef APPROX_ERR_MAX_EN
    r.mx = m_mx;
`else
    r.mx = 0;
`endif
    exp_q.push_back(r);
  endtask

  task automatic cmp_res(input string tag);
    check({tag, "_sq"},  64'(sum_sq_err),  64'(cur.sq));
    check({tag, "_abs"}, 64'(sum_abs_err), 64'(cur.ab));
    check({tag, "_cnt"}, 64'(err_cnt),     64'(cur.cnt));
    check({tag, "_max"}, 64'(max_abs_err), 64'(cur.mx));
  endtask

  // Wait for res_valid, check latency and values, optionally hold res_ready low.
  task automatic get_result(input string tag, input int hold, input bit poke_start);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      check({tag, "_res_timeout"}, 64'd0, 64'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd0, 64'd1);
    end else begin
      cur = exp_q.pop_front();
      check({tag, "_latency"}, 64'(cyc - last_acc), 64'd4);
      cmp_res(tag);
      for (int i = 0; i < hold; i++) begin
        if (poke_start && i == 3) begin
          win_len = 16'd5;
          start = 1'b1;
        end
        tick();
        start = 1'b0;
        check({tag, "_hold_valid"}, {63'd0, res_valid}, 64'd1);
        check({tag, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_hold_sq"}, 64'(sum_sq_err), 64'(cur.sq));
        check({tag, "_hold_cnt"}, 64'(err_cnt), 64'(cur.cnt));
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check({tag, "_valid_drop"}, {63'd0, res_valid}, 64'd0);
      check({tag, "_idle"}, {63'd0, busy}, 64'd0);
      check({tag, "_kept_abs"}, 64'(sum_abs_err), 64'(cur.ab));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_busy"},  {63'd0, busy}, 64'd0);
    check({tag, "_valid"}, {63'd0, res_valid}, 64'd0);
    check({tag, "_sq"},    64'(sum_sq_err), 64'd0);
    check({tag, "_abs"},   64'(sum_abs_err), 64'd0);
    check({tag, "_cnt"},   64'(err_cnt), 64'd0);
    check({tag, "_max"},   64'(max_abs_err), 64'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    rst = 1'b0;
    check_zero("reset");

    // Exact stream
    open_win(4);
    send(3, 5, 15);
    send(255, 255, 65025);
    send(0, 7, 0);
    send(16, 16, 256);
    close_win();
    get_result("exact", 0, 1'b0);

    // Worst single error
    open_win(1);
    send(255, 255, 0);
    close_win();
    get_result("worst", 0, 1'b0);

    // Mixed sign, with backpressure and ignored start in RESULT
    open_win(2);
    send(2, 3, 4);
    send(2, 3, 9);
    close_win();
    get_result("mixed", 10, 1'b1);

    // Gaps between valid beats
    open_win(2);
    send(4, 4, 20);
    bubble();
    send(1, 1, 0);
    bubble();
    close_win();
    get_result("gaps", 0, 1'b0);

    // Reset in the middle of a window
    open_win(8);
    send(9, 9, 0);
    send(7, 7, 1);
    send(200, 100, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("midrst");
    open_win(1);
    send(10, 10, 90);
    close_win();
    get_result("after_rst", 0, 1'b0);

    // Full 2^CNT_W window with exhaustive exact pairs
    open_win(0);
    for (int i = 0; i < 65536; i++) begin
      send(i / 256, i % 256, (i / 256) * (i % 256));
      if (i == 65534) check("full_ready_before_last", {63'd0, in_ready}, 64'd1);
    end
    check("full_ready_after_last", {63'd0, in_ready}, 64'd0);
    close_win();
    get_result("full", 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
